// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcodes,
// ALU operation classes and branch condition codes.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd5
  } ctrl_state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BLEZ  = 6'd6;
  localparam logic [5:0] OP_BGTZ  = 6'd7;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [2:0] ALU_R     = 3'b000;
  localparam logic [2:0] ALU_ADDI  = 3'b001;
  localparam logic [2:0] ALU_SLTIU = 3'b010;
  localparam logic [2:0] ALU_LUI   = 3'b011;
  localparam logic [2:0] ALU_MEM   = 3'b101;
  localparam logic [2:0] ALU_BR    = 3'b110;
  localparam logic [2:0] ALU_ORI   = 3'b111;

  localparam logic [1:0] BR_EQ  = 2'd0;
  localparam logic [1:0] BR_NE  = 2'd1;
  localparam logic [1:0] BR_LEZ = 2'd2;
  localparam logic [1:0] BR_GTZ = 2'd3;

  localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/op_ctrl_decode.sv
// Opcode to control-class decode; purely combinational, no state, no backpressure.
// The FSM decides in which state each of these takes effect.
module op_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] op,
  output logic       legal,
  output logic       is_rtype,
  output logic       is_jump,
  output logic       is_branch,
  output logic       is_load,
  output logic       is_store,
  output logic       alu_src,
  output logic [2:0] alu_op,
  output logic [1:0] branch_type
);

  always_comb begin
    legal       = 1'b1;
    is_rtype    = 1'b0;
    is_jump     = 1'b0;
    is_branch   = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    alu_src     = 1'b0;
    alu_op      = ALU_R;
    branch_type = BR_EQ;
    case (op)
      OP_RTYPE: is_rtype = 1'b1;
      OP_J:     is_jump  = 1'b1;
      OP_BEQ:   begin is_branch = 1'b1; alu_op = ALU_BR; branch_type = BR_EQ;  end
      OP_BNE:   begin is_branch = 1'b1; alu_op = ALU_BR; branch_type = BR_NE;  end
      OP_BLEZ:  begin is_branch = 1'b1; alu_op = ALU_BR; branch_type = BR_LEZ; end
      OP_BGTZ:  begin is_branch = 1'b1; alu_op = ALU_BR; branch_type = BR_GTZ; end
      OP_ADDI:  begin alu_src = 1'b1; alu_op = ALU_ADDI;  end
      OP_SLTIU: begin alu_src = 1'b1; alu_op = ALU_SLTIU; end
      OP_ORI:   begin alu_src = 1'b1; alu_op = ALU_ORI;   end
      OP_LUI:   begin alu_src = 1'b1; alu_op = ALU_LUI;   end
      OP_LW:    begin is_load  = 1'b1; alu_src = 1'b1; alu_op = ALU_MEM; end
      OP_SW:    begin is_store = 1'b1; alu_src = 1'b1; alu_op = ALU_MEM; end
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM (IF/ID/EX/MEM/WB/ERR); j 2, branch 3, sw/ALU 4, lw 5 cycles
// at zero wait; IF/MEM stall on mem_ready_i and time out to ERR after WAIT_MAX cycles.
module multi_cycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [5:0]          instr_op_i,
  input  logic                mem_ready_i,
  output logic                ir_write_o,
  output logic                pc_write_o,
  output logic                RegWrite_o,
  output logic                RegDst_o,
  output logic                ALUSrc_o,
  output logic                Branch_o,
  output logic                jump_o,
  output logic [ALU_OP_W-1:0] ALU_op_o,
  output logic [1:0]          branch_type_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                mem_to_reg_o,
  output logic [2:0]          state_o,
  output logic                illegal_o,
  output logic                timeout_o
);

  // The counter holds the number of stalled cycles already spent, so the
  // WAIT_MAX-th stalled cycle is the one that sees WAIT_LAST.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_MAX - 1);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

  ctrl_state_e           state_q, state_d;
  logic [5:0]            op_q;
  logic [5:0]            op_sel;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  wait_hit;
  logic                  illegal_q, timeout_q;
  logic                  set_illegal, set_timeout;

  logic       dec_legal, dec_rtype, dec_jump, dec_branch, dec_load, dec_store, dec_alu_src;
  logic [2:0] dec_alu_op;
  logic [1:0] dec_branch_type;

  // ID decodes the live opcode because op_q only captures it at the end of ID.
  assign op_sel   = (state_q == S_ID) ? instr_op_i : op_q;
  assign wait_hit = (wait_cnt == WAIT_LAST);

  op_ctrl_decode u_decode (
    .op          (op_sel),
    .legal       (dec_legal),
    .is_rtype    (dec_rtype),
    .is_jump     (dec_jump),
    .is_branch   (dec_branch),
    .is_load     (dec_load),
    .is_store    (dec_store),
    .alu_src     (dec_alu_src),
    .alu_op      (dec_alu_op),
    .branch_type (dec_branch_type)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IF;
      op_q      <= '0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) op_q <= instr_op_i;
      if (state_d != state_q)
        wait_cnt <= '0;
      else if ((state_q == S_IF || state_q == S_MEM) && !mem_ready_i)
        wait_cnt <= wait_cnt + CNT_ONE;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    set_illegal   = 1'b0;
    set_timeout   = 1'b0;
    ir_write_o    = 1'b0;
    pc_write_o    = 1'b0;
    RegWrite_o    = 1'b0;
    RegDst_o      = 1'b0;
    ALUSrc_o      = 1'b0;
    Branch_o      = 1'b0;
    jump_o        = 1'b0;
    ALU_op_o      = '0;
    branch_type_o = 2'd0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    mem_to_reg_o  = 1'b0;
    state_o       = state_q;
    illegal_o     = illegal_q;
    timeout_o     = timeout_q;

    case (state_q)
      S_IF: begin
        mem_read_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_ID;
        end else if (wait_hit) begin
          set_timeout = 1'b1;
          state_d     = S_ERR;
        end
      end
      S_ID: begin
        if (!dec_legal) begin
          set_illegal = 1'b1;
          state_d     = S_ERR;
        end else if (dec_jump) begin
          jump_o     = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        ALU_op_o = ALU_OP_W'(dec_alu_op);
        ALUSrc_o = dec_alu_src;
        if (dec_branch) begin
          Branch_o      = 1'b1;
          branch_type_o = dec_branch_type;
          state_d       = S_IF;
        end else if (dec_load || dec_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_read_o  = dec_load;
        mem_write_o = dec_store;
        if (mem_ready_i) begin
          state_d = dec_load ? S_WB : S_IF;
        end else if (wait_hit) begin
          set_timeout = 1'b1;
          state_d     = S_ERR;
        end
      end
      S_WB: begin
        RegWrite_o   = 1'b1;
        RegDst_o     = dec_rtype;
        mem_to_reg_o = dec_load;
        state_d      = S_IF;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase

    // Reset silences every strobe combinationally so an aborted store never
    // sees a final write cycle.
    if (rst_i) begin
      ir_write_o    = 1'b0;
      pc_write_o    = 1'b0;
      RegWrite_o    = 1'b0;
      RegDst_o      = 1'b0;
      ALUSrc_o      = 1'b0;
      Branch_o      = 1'b0;
      jump_o        = 1'b0;
      ALU_op_o      = '0;
      branch_type_o = 2'd0;
      mem_read_o    = 1'b0;
      mem_write_o   = 1'b0;
      mem_to_reg_o  = 1'b0;
      state_o       = 3'd0;
      illegal_o     = 1'b0;
      timeout_o     = 1'b0;
    end
  end

endmodule
